// File: rtl/ref_window_loader_if.sv
// Stream-in / window-out bundle for the reference window loader.
// slave = loader side, master = producer/consumer side.
interface ref_window_loader_if #(
    parameter int NUM_PIXEL     = 8,
    parameter int SIZE_OF_PIXEL = 8
);
    localparam int SIDE  = NUM_PIXEL + 7;
    localparam int WIN_W = SIDE * SIDE * SIZE_OF_PIXEL;

    logic                               s_valid;
    logic                               s_ready;
    logic [NUM_PIXEL*SIZE_OF_PIXEL-1:0] s_data;
    logic                               s_last;
    logic                               win_valid;
    logic                               win_ack;
    logic [WIN_W-1:0]                   win_data;
    logic                               err_framing;
    logic [7:0]                         win_count;

    modport slave (
        input  s_valid, s_data, s_last, win_ack,
        output s_ready, win_valid, win_data, err_framing, win_count
    );

    modport master (
        output s_valid, s_data, s_last, win_ack,
        input  s_ready, win_valid, win_data, err_framing, win_count
    );
endinterface

// File: rtl/ref_window_loader.sv
// Packs 64-bit pixel beats into a double-buffered 15x15 reference window
// for the subpixel interpolator; two beats per row, 30 beats per window.
module ref_window_loader #(
    parameter int NUM_PIXEL     = 8,
    parameter int SIZE_OF_PIXEL = 8
) (
    input logic               clk,
    input logic               rst,
    ref_window_loader_if.slave bus
);
    localparam int SIDE  = NUM_PIXEL + 7;
    localparam int WIN_W = SIDE * SIDE * SIZE_OF_PIXEL;
    localparam int BEATS = 2 * SIDE;
    localparam int TAIL  = SIDE - NUM_PIXEL;

    logic [1:0][WIN_W-1:0] r_bank;
    logic [1:0]            r_full;
    logic                  r_wr_bank;
    logic                  r_rd_bank;
    logic [4:0]            r_beat;
    logic                  r_err;
    logic [7:0]            r_count;

    logic                  w_accept;
    logic                  w_last_beat;
    logic                  w_ack;
    logic [3:0]            w_row;

    assign w_accept    = bus.s_valid && bus.s_ready;
    assign w_last_beat = (r_beat == 5'(BEATS - 1));
    assign w_ack       = bus.win_ack && r_full[r_rd_bank];
    assign w_row       = r_beat[4:1];

    assign bus.s_ready     = ~r_full[r_wr_bank];
    assign bus.win_valid   = r_full[r_rd_bank];
    assign bus.win_data    = r_bank[r_rd_bank];
    assign bus.err_framing = r_err;
    assign bus.win_count   = r_count;

    // Even beats carry cols 0..7 of the row, odd beats cols 8..14 (top byte unused).
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_bank <= '0;
        end else if (w_accept) begin
            for (int c = 0; c < NUM_PIXEL; c++) begin
                if (!r_beat[0]) begin
                    r_bank[r_wr_bank][(int'(w_row) * SIDE + c) * SIZE_OF_PIXEL +: SIZE_OF_PIXEL]
                        <= bus.s_data[c * SIZE_OF_PIXEL +: SIZE_OF_PIXEL];
                end else if (c < TAIL) begin
                    r_bank[r_wr_bank][(int'(w_row) * SIDE + NUM_PIXEL + c) * SIZE_OF_PIXEL +: SIZE_OF_PIXEL]
                        <= bus.s_data[c * SIZE_OF_PIXEL +: SIZE_OF_PIXEL];
                end
            end
        end
    end

    // Fill completion and ack never touch the same full flag: a bank being
    // filled is empty, so it cannot also be the presented (acked) bank.
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_full    <= '0;
            r_wr_bank <= 1'b0;
            r_rd_bank <= 1'b0;
            r_beat    <= '0;
            r_err     <= 1'b0;
            r_count   <= '0;
        end else begin
            if (w_accept) begin
                if (w_last_beat) begin
                    r_full[r_wr_bank] <= 1'b1;
                    r_wr_bank         <= ~r_wr_bank;
                    r_beat            <= '0;
                    if (!bus.s_last)
                        r_err <= 1'b1;
                end else if (bus.s_last) begin
                    // Early end of window: drop the partial fill, keep the bank.
                    r_err  <= 1'b1;
                    r_beat <= '0;
                end else begin
                    r_beat <= r_beat + 5'd1;
                end
            end
            if (w_ack) begin
                r_full[r_rd_bank] <= 1'b0;
                r_rd_bank         <= ~r_rd_bank;
                r_count           <= r_count + 8'd1;
            end
        end
    end
endmodule
